// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and instruction_mem (slave).
// The word on mem_inst is a combinational function of mem_adr; there is no handshake.
interface instruction_fetch_if #(
    parameter int ADDRESS_LEN = 8,
    parameter int WORD_LEN    = 32
);
    logic [ADDRESS_LEN-1:0] mem_adr;
    logic [WORD_LEN-1:0]    mem_inst;

    modport master (output mem_adr, input  mem_inst);
    modport slave  (input  mem_adr, output mem_inst);
endinterface

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the word-addressed PC, drives instruction memory, fills IF/ID.
// Optional macro FETCH_BOUND_EN stops fetching at the MEMORY_SIZE bound and adds the halted port.
module instruction_fetch #(
`ifdef FETCH_BOUND_EN
    parameter int                    MEMORY_SIZE = 200,
`endif
    parameter int                    ADDRESS_LEN = 8,
    parameter int                    WORD_LEN    = 32,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC   = '0,
    parameter logic [WORD_LEN-1:0]    NOP_WORD   = 32'h0400_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_target,
    instruction_fetch_if.master    mem,
    output logic [WORD_LEN-1:0]    if_id_inst,
    output logic [ADDRESS_LEN-1:0] if_id_pc_plus1,
`ifdef FETCH_BOUND_EN
    output logic                   halted,
`endif
    output logic                   if_id_valid
);

`ifdef FETCH_BOUND_EN
    localparam logic [ADDRESS_LEN:0]   MEM_SIZE_X = MEMORY_SIZE[ADDRESS_LEN:0];
    localparam logic [ADDRESS_LEN-1:0] LAST_ADR   = ADDRESS_LEN'(MEMORY_SIZE - 1);
`endif

    logic [ADDRESS_LEN-1:0] pc_p0;
    logic [ADDRESS_LEN-1:0] pc_plus1;

    assign pc_plus1    = pc_p0 + ADDRESS_LEN'(1);
    assign mem.mem_adr = pc_p0;

    // ---- PC (stage 0) -> IF/ID register (stage 1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0          <= RESET_PC;
            if_id_inst     <= NOP_WORD;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
`ifdef FETCH_BOUND_EN
            halted         <= 1'b0;
`endif
        end else if (branch_taken) begin
            if_id_inst     <= NOP_WORD;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
`ifdef FETCH_BOUND_EN
            // An out-of-range target parks the PC where it is rather than fetching garbage.
            if ({1'b0, branch_target} < MEM_SIZE_X) begin
                pc_p0  <= branch_target;
                halted <= 1'b0;
            end else begin
                halted <= 1'b1;
            end
`else
            pc_p0          <= branch_target;
`endif
`ifdef FETCH_BOUND_EN
        end else if (halted) begin
            if_id_inst     <= NOP_WORD;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
`endif
        end else if (!stall) begin
            if_id_inst     <= mem.mem_inst;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid    <= 1'b1;
`ifdef FETCH_BOUND_EN
            // The last word is still delivered; the PC then stays on it.
            if (pc_p0 == LAST_ADR) begin
                halted <= 1'b1;
            end else begin
                pc_p0  <= pc_plus1;
            end
`else
            pc_p0          <= pc_plus1;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch against a cycle-level reference model.
// Honors FETCH_BOUND_EN the same way as the design.
module tb_instruction_fetch;

    localparam int AL       = 8;
    localparam int WL       = 32;
    localparam int ASPACE   = 1 << AL;
    localparam int MEM_SIZE = 200;
    localparam logic [WL-1:0] NOP = 32'h0400_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AL-1:0] branch_target = '0;
    logic [WL-1:0] if_id_inst;
    logic [AL-1:0] if_id_pc_plus1;
    logic          if_id_valid;
    logic          halted_obs;

    logic [WL-1:0] mem [ASPACE];

    instruction_fetch_if #(.ADDRESS_LEN(AL), .WORD_LEN(WL)) bus ();
    assign bus.mem_inst = mem[bus.mem_adr];

`ifdef FETCH_BOUND_EN
    logic halted;
    assign halted_obs = halted;
`else
    assign halted_obs = 1'b0;
`endif

    instruction_fetch #(
`ifdef FETCH_BOUND_EN
        .MEMORY_SIZE(MEM_SIZE),
`endif
        .ADDRESS_LEN(AL),
        .WORD_LEN(WL),
        .RESET_PC('0),
        .NOP_WORD(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .mem(bus),
        .if_id_inst(if_id_inst),
        .if_id_pc_plus1(if_id_pc_plus1),
`ifdef FETCH_BOUND_EN
        .halted(halted),
`endif
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what a fetch stage should look like after each edge.
    int          m_pc;
    logic [WL-1:0] m_inst;
    int          m_ppc;
    bit          m_valid;
    bit          m_halt;
    bit          bound_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input string tag, input bit r, input bit s, input bit b, input int t);
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = AL'(t);
        if (r) begin
            m_pc = 0; m_inst = NOP; m_ppc = 0; m_valid = 0; m_halt = 0;
        end else if (b) begin
            m_inst = NOP; m_ppc = 0; m_valid = 0;
            if (!bound_en || t < MEM_SIZE) begin
                m_pc   = t;
                m_halt = 0;
            end else begin
                m_halt = 1;
            end
        end else if (m_halt) begin
            m_inst = NOP; m_ppc = 0; m_valid = 0;
        end else if (!s) begin
            m_inst  = mem[m_pc];
            m_ppc   = (m_pc + 1) % ASPACE;
            m_valid = 1;
            if (bound_en && m_pc == MEM_SIZE - 1) m_halt = 1;
            else m_pc = (m_pc + 1) % ASPACE;
        end
        @(posedge clk);
        #1;
        check({tag, ".adr"},   32'(bus.mem_adr),    32'(m_pc));
        check({tag, ".inst"},  if_id_inst,          m_inst);
        check({tag, ".ppc"},   32'(if_id_pc_plus1), 32'(m_ppc));
        check({tag, ".valid"}, 32'(if_id_valid),    32'(m_valid));
        check({tag, ".halt"},  32'(halted_obs),     32'(m_halt));
    endtask

    initial begin
`ifdef FETCH_BOUND_EN
        bound_en = 1;
`else
        bound_en = 0;
`endif
        for (int i = 0; i < ASPACE; i++) mem[i] = $urandom;

        // Reset held for two edges
        step("rst0", 1, 0, 0, 0);
        step("rst1", 1, 0, 0, 0);
        check("rst_adr",   32'(bus.mem_adr), 32'd0);
        check("rst_valid", 32'(if_id_valid), 32'd0);
        check("rst_inst",  if_id_inst,       32'h0400_0000);

        // Sequential fetch
        step("seq", 0, 0, 0, 0);
        check("seq0_inst", if_id_inst, mem[0]);
        check("seq0_ppc",  32'(if_id_pc_plus1), 32'd1);
        step("seq", 0, 0, 0, 0);
        check("seq1_inst", if_id_inst, mem[1]);
        step("seq", 0, 0, 0, 0);
        check("seq2_inst", if_id_inst, mem[2]);
        check("seq2_ppc",  32'(if_id_pc_plus1), 32'd3);
        check("seq_adr",   32'(bus.mem_adr), 32'd3);

        // Stall for two cycles, then resume with mem[3]
        step("stall", 0, 1, 0, 0);
        step("stall", 0, 1, 0, 0);
        check("stall_adr",  32'(bus.mem_adr), 32'd3);
        check("stall_inst", if_id_inst, mem[2]);
        step("resume", 0, 0, 0, 0);
        check("resume_inst", if_id_inst, mem[3]);

        // Branch at adr 4 to 5
        step("br", 0, 0, 1, 5);
        check("br_adr",   32'(bus.mem_adr), 32'd5);
        check("br_valid", 32'(if_id_valid), 32'd0);
        step("br_fill", 0, 0, 0, 0);
        check("br_inst", if_id_inst, mem[5]);
        check("br_ppc",  32'(if_id_pc_plus1), 32'd6);

        // Branch with concurrent stall
        step("brst", 0, 1, 1, 10);
        check("brst_adr", 32'(bus.mem_adr), 32'd10);
        check("brst_inst", if_id_inst, NOP);
        step("brst_fill", 0, 0, 0, 0);

        if (bound_en) begin
            step("bnd_br", 0, 0, 1, MEM_SIZE - 1);
            step("bnd_last", 0, 0, 0, 0);
            check("bnd_last_inst", if_id_inst, mem[MEM_SIZE-1]);
            check("bnd_halt", 32'(halted_obs), 32'd1);
            step("bnd_bub", 0, 0, 0, 0);
            step("bnd_bub", 0, 1, 0, 0);
            check("bnd_hold_adr", 32'(bus.mem_adr), 32'(MEM_SIZE - 1));
            step("bnd_clr", 0, 0, 1, 0);
            check("bnd_clr_halt", 32'(halted_obs), 32'd0);
            step("bnd_far", 0, 0, 1, MEM_SIZE + 7);
            check("bnd_far_adr", 32'(bus.mem_adr), 32'd0);
            step("bnd_far_bub", 0, 0, 0, 0);
            step("bnd_clr2", 0, 0, 1, 3);
        end else begin
            step("wrap_br", 0, 0, 1, ASPACE - 1);
            step("wrap", 0, 0, 0, 0);
            check("wrap_adr", 32'(bus.mem_adr), 32'd0);
            check("wrap_ppc", 32'(if_id_pc_plus1), 32'd0);
            step("wrap2", 0, 0, 0, 0);
            check("wrap2_inst", if_id_inst, mem[0]);
        end

        // Randomized traffic, including mid-stream reset
        for (int i = 0; i < 2000; i++) begin
            bit r, s, b;
            int t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            b = ($urandom_range(0, 99) < 10);
            t = (($urandom_range(0, 3) == 0) ? (ASPACE - 1 - int'($urandom_range(0, 2)))
                                              : int'($urandom_range(0, ASPACE - 1)));
            step("rnd", r, s, b, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
